// File: rtl/sparse_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sparse_pkg
//  Description : Shared defaults and FSM state type for the sparse packer.
//  Revision    : 1.0  initial release
// ============================================================================
package sparse_pkg;

  localparam int c_DATA_W = 16;   // element width
  localparam int c_DEPTH  = 64;   // elements per tile / buffer depth
  localparam int c_IDX_W  = 6;    // log2(c_DEPTH)

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCEPT = 3'd1,
    ST_WRITE  = 3'd2,
    ST_GAP    = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/sparse_zero_detect.sv
`default_nettype none
// ============================================================================
//  Module      : sparse_zero_detect
//  Description : Combinational classifier deciding whether an element counts
//                as zero. Default build: exact zero compare. With the macro
//                SPARSE_PACKER_THRESH_EN defined, an element is zero when its
//                signed magnitude is <= thresh; the most negative value has
//                no representable magnitude and is always nonzero.
//  Revision    : 1.0  initial release
// ============================================================================
module sparse_zero_detect
  import sparse_pkg::*;
#(
  parameter int DATA_W = c_DATA_W
) (
  input  logic [DATA_W-1:0]        data,
`ifdef SPARSE_PACKER_THRESH_EN
  input  logic signed [DATA_W-1:0] thresh,
`endif
  output logic                     is_zero
);

`ifdef SPARSE_PACKER_THRESH_EN
  localparam logic [DATA_W-1:0] c_MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  logic signed [DATA_W-1:0] w_sdata;
  logic signed [DATA_W-1:0] w_mag;
  logic                     w_is_min;

  // Magnitude compare against the signed threshold.
  always_comb begin
    w_sdata  = signed'(data);
    w_is_min = (data == c_MOST_NEG);
    w_mag    = w_sdata[DATA_W-1] ? -w_sdata : w_sdata;
    is_zero  = !w_is_min && (w_mag <= thresh);
  end
`else
  // Exact zero compare.
  always_comb begin
    is_zero = (data == '0);
  end
`endif

endmodule
`default_nettype wire

// File: rtl/sparse_packer.sv
`default_nettype none
// ============================================================================
//  Module      : sparse_packer
//  Description : Accepts a dense element stream for one tile, writes only the
//                nonzero elements to a buffer (one wr_en pulse each, always
//                separated by a low cycle), and records a position mask and a
//                count of nonzero elements. Tiles longer than DEPTH are
//                force-terminated and flagged in the sticky overflow bit.
//                Optional build macro: SPARSE_PACKER_THRESH_EN adds a signed
//                thresh input for magnitude-based zero detection.
//  Revision    : 1.0  initial release
// ============================================================================
module sparse_packer
  import sparse_pkg::*;
#(
  parameter int DATA_W = c_DATA_W,
  parameter int DEPTH  = c_DEPTH,
  parameter int IDX_W  = c_IDX_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_last,
`ifdef SPARSE_PACKER_THRESH_EN
  input  logic signed [DATA_W-1:0] thresh,
`endif
  output logic                     wr_en,
  output logic [DATA_W-1:0]        wr_data,
  output logic [DEPTH-1:0]         nz_mask,
  output logic [IDX_W:0]           nz_count,
  output logic                     done,
  output logic                     overflow
);

  localparam logic [IDX_W:0] c_POS_LAST = (IDX_W+1)'(DEPTH-1);
  localparam logic [IDX_W:0] c_ONE      = (IDX_W+1)'(1);

  state_t              r_state;
  state_t              w_next;
  logic [IDX_W:0]      r_pos;
  logic [DATA_W-1:0]   r_data;
  logic                r_last;
  logic                w_is_zero;
  logic                w_hs;
  logic                w_at_end;
  logic                w_last_eff;
  logic                w_ovf_hit;

  sparse_zero_detect #(
    .DATA_W (DATA_W)
  ) u_zero_detect (
    .data    (in_data),
`ifdef SPARSE_PACKER_THRESH_EN
    .thresh  (thresh),
`endif
    .is_zero (w_is_zero)
  );

  // Handshake qualification; the final slot terminates the tile even without in_last.
  always_comb begin
    w_hs       = in_valid && (r_state == ST_ACCEPT);
    w_at_end   = (r_pos == c_POS_LAST);
    w_last_eff = in_last || w_at_end;
    w_ovf_hit  = w_hs && w_at_end && !in_last;
  end

  // State register; reset drops any partial tile immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    w_next   = r_state;
    in_ready = 1'b0;
    wr_en    = 1'b0;
    done     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_next = ST_ACCEPT;
      end
      ST_ACCEPT: begin
        in_ready = 1'b1;
        if (w_hs) begin
          if (!w_is_zero)      w_next = ST_WRITE;
          else if (w_last_eff) w_next = ST_DONE;
        end
      end
      ST_WRITE: begin
        wr_en  = 1'b1;
        w_next = ST_GAP;
      end
      ST_GAP: begin
        // Guaranteed low cycle so the edge-armed buffer sees a fresh rising edge.
        w_next = r_last ? ST_DONE : ST_ACCEPT;
      end
      ST_DONE: begin
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Tile bookkeeping: position, mask, count, overflow and the latched element.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pos    <= '0;
      r_data   <= '0;
      r_last   <= 1'b0;
      nz_mask  <= '0;
      nz_count <= '0;
      overflow <= 1'b0;
    end else begin
      if ((r_state == ST_IDLE) && start) begin
        r_pos    <= '0;
        nz_mask  <= '0;
        nz_count <= '0;
        overflow <= 1'b0;
      end
      if (w_hs) begin
        r_pos <= r_pos + c_ONE;
        if (!w_is_zero) begin
          r_data                     <= in_data;
          r_last                     <= w_last_eff;
          nz_mask[r_pos[IDX_W-1:0]]  <= 1'b1;
        end
        if (w_ovf_hit) overflow <= 1'b1;
      end
      if (r_state == ST_WRITE) begin
        nz_count <= nz_count + c_ONE;
      end
    end
  end

  // The write bus only changes when a new nonzero element is latched.
  assign wr_data = r_data;

endmodule
`default_nettype wire

// File: tb/tb_sparse_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sparse_packer
//  Description : Scoreboard bench for sparse_packer: directed and random tiles
//                checked against a list-based reference model.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sparse_packer;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 64;
  localparam int IDX_W  = 6;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_last = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic [DEPTH-1:0]  nz_mask;
  logic [IDX_W:0]    nz_count;
  logic              done;
  logic              overflow;
`ifdef SPARSE_PACKER_THRESH_EN
  logic signed [DATA_W-1:0] thresh = '0;
`endif

  int checks   = 0;
  int failures = 0;

  logic [DATA_W-1:0] exp_q[$];
  logic [DEPTH-1:0]  exp_mask = '0;
  int                exp_count = 0;
  logic              exp_ovf = 1'b0;
  int                exp_accept = 0;
  int                done_cnt = 0;

  always #5 clk = ~clk;

  sparse_packer #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
`ifdef SPARSE_PACKER_THRESH_EN
    .thresh   (thresh),
`endif
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .nz_mask  (nz_mask),
    .nz_count (nz_count),
    .done     (done),
    .overflow (overflow)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference zero rule, expressed on signed integers.
  function automatic bit ref_zero(input logic [DATA_W-1:0] x);
`ifdef SPARSE_PACKER_THRESH_EN
    int v;
    v = int'($signed(x));
    if (v == -(2 ** (DATA_W-1))) return 1'b0;
    if (v < 0) v = -v;
    return v <= int'(thresh);
`else
    return x == '0;
`endif
  endfunction

  // Reference model: walk the dense list, stop at the first last or the final slot.
  task automatic build_expect(input logic [DATA_W-1:0] d[$], input logic l[$]);
    bit term;
    exp_mask   = '0;
    exp_count  = 0;
    exp_ovf    = 1'b0;
    exp_accept = 0;
    exp_q.delete();
    for (int i = 0; i < d.size(); i++) begin
      term = l[i];
      if (i == DEPTH-1 && !l[i]) begin
        exp_ovf = 1'b1;
        term    = 1'b1;
      end
      exp_accept++;
      if (!ref_zero(d[i])) begin
        exp_mask[i] = 1'b1;
        exp_count++;
        exp_q.push_back(d[i]);
      end
      if (term) break;
    end
  endtask

  // Monitor: pops expected writes, checks pulse spacing and end-of-tile state.
  initial begin
    logic              prev_wr;
    logic [DATA_W-1:0] e;
    prev_wr = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_wr = 1'b0;
      end else begin
        if (wr_en) begin
          check("wr_gap", {63'd0, prev_wr}, 64'd0);
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL wr_unexpected actual=%0h required=no_write", wr_data);
          end else begin
            e = exp_q.pop_front();
            check("wr_data", {48'd0, wr_data}, {48'd0, e});
          end
        end
        prev_wr = wr_en;
        if (done) begin
          done_cnt++;
          check("done_mask",     nz_mask, exp_mask);
          check("done_count",    {57'd0, nz_count}, 64'(exp_count));
          check("done_overflow", {63'd0, overflow}, {63'd0, exp_ovf});
          check("done_missing_writes", 64'(exp_q.size()), 64'd0);
        end
      end
    end
  end

  task automatic run_tile(input logic [DATA_W-1:0] d[$], input logic l[$],
                          input bit rand_valid, input bit poke_start);
    int idx;
    int cyc;
    int dc0;
    bit poked;
    idx   = 0;
    cyc   = 0;
    poked = 1'b0;
    build_expect(d, l);
    dc0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (done_cnt == dc0 && cyc < 3000) begin
      if (idx < d.size()) begin
        in_valid = rand_valid ? ($urandom_range(0, 1) == 1) : 1'b1;
        in_data  = d[idx];
        in_last  = l[idx];
      end else begin
        in_valid = 1'b0;
      end
      if (poke_start && !poked && idx == 3) begin
        start = 1'b1;
        poked = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    start    = 1'b0;
    if (done_cnt == dc0) begin
      checks++;
      failures++;
      $display("FAIL tile_timeout actual=no_done required=done");
    end
    check("accepted", 64'(idx), 64'(exp_accept));
    repeat (3) @(posedge clk);
    #1;
    check("hold_mask",  nz_mask, exp_mask);
    check("hold_count", {57'd0, nz_count}, 64'(exp_count));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, {63'd0, in_ready}, 64'd0);
    check({tag, "_wr_en"},    {63'd0, wr_en}, 64'd0);
    check({tag, "_wr_data"},  {48'd0, wr_data}, 64'd0);
    check({tag, "_nz_mask"},  nz_mask, 64'd0);
    check({tag, "_nz_count"}, {57'd0, nz_count}, 64'd0);
    check({tag, "_done"},     {63'd0, done}, 64'd0);
    check({tag, "_overflow"}, {63'd0, overflow}, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] d[$];
    logic              l[$];
    int                cyc;
    logic [DATA_W-1:0] v;

    #2 reset = 1'b1;
    #2 check_reset_values("reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Mixed tile: writes 5, 7, -3; mask 0x32.
    d = {}; l = {};
    d.push_back(16'd0);    l.push_back(1'b0);
    d.push_back(16'd5);    l.push_back(1'b0);
    d.push_back(16'd0);    l.push_back(1'b0);
    d.push_back(16'd0);    l.push_back(1'b0);
    d.push_back(16'd7);    l.push_back(1'b0);
    d.push_back(16'hFFFD); l.push_back(1'b1);
    run_tile(d, l, 1'b0, 1'b0);
    check("mixed_mask_literal", nz_mask, 64'h32);

    // Full tile of zeros, last on element 63.
    d = {}; l = {};
    for (int i = 0; i < DEPTH; i++) begin
      d.push_back('0);
      l.push_back(i == DEPTH-1);
    end
    run_tile(d, l, 1'b0, 1'b0);
    check("zeros_overflow", {63'd0, overflow}, 64'd0);

    // 65 nonzero elements, no last: forced termination.
    d = {}; l = {};
    for (int i = 0; i < DEPTH+1; i++) begin
      d.push_back(DATA_W'(i + 1));
      l.push_back(1'b0);
    end
    run_tile(d, l, 1'b0, 1'b0);
    check("ovf_count_literal", {57'd0, nz_count}, 64'd64);
    check("ovf_flag", {63'd0, overflow}, 64'd1);

    // Reset while in WRITE.
    exp_q.delete();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'd9;
    in_last  = 1'b0;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!wr_en && cyc < 20);
    in_valid = 1'b0;
    check("midtile_wr_en_seen", {63'd0, wr_en}, 64'd1);
    #2 reset = 1'b1;
    #1 check_reset_values("midtile_reset");
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    // Clean tile after the reset.
    d = {}; l = {};
    d.push_back(16'd4); l.push_back(1'b0);
    d.push_back(16'd0); l.push_back(1'b0);
    d.push_back(16'd6); l.push_back(1'b1);
    run_tile(d, l, 1'b0, 1'b0);

    // Random 10-element tiles with toggling valid and a stray start.
    for (int t = 0; t < 20; t++) begin
      d = {}; l = {};
      for (int i = 0; i < 10; i++) begin
        if ($urandom_range(0, 1) == 0) begin
          v = '0;
        end else begin
          v = DATA_W'($urandom);
          if (v == '0) v = 16'd1;
        end
        d.push_back(v);
        l.push_back(i == 9);
      end
      run_tile(d, l, 1'b1, 1'b1);
    end

`ifdef SPARSE_PACKER_THRESH_EN
    thresh = 16'sd2;
    d = {}; l = {};
    d.push_back(16'd1);    l.push_back(1'b0);
    d.push_back(16'hFFFE); l.push_back(1'b0);
    d.push_back(16'd3);    l.push_back(1'b0);
    d.push_back(16'hFFFC); l.push_back(1'b1);
    run_tile(d, l, 1'b0, 1'b0);
    check("thresh_mask_literal", nz_mask, 64'hC);

    d = {}; l = {};
    d.push_back(16'h8000); l.push_back(1'b0);
    d.push_back(16'h7FFF); l.push_back(1'b0);
    d.push_back(16'd2);    l.push_back(1'b1);
    run_tile(d, l, 1'b1, 1'b0);
    thresh = '0;
`endif

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
